// File: rtl/dht_sensor_reader.sv
`timescale 1ns/1ps
// DHT11/DHT22 single-wire reader: 1 us timebase, handshake FSM, 40-bit frame capture, checksum.
// Optional build macro DHT_GLITCH_FILTER_EN adds a 3-sample stability filter on the synced pin.

module dht_sensor_reader #(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned SENSOR_TYPE   = 0,
    parameter int unsigned GAP_MS        = 1000,
    parameter int unsigned BIT_THRESH_US = 48
) (
    input  logic        clock,
    input  logic        reset_n,
    inout  wire         data,
    input  logic        start,
    input  logic        auto_en,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic        valid,
    output logic        busy,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam int unsigned PRESC    = CLK_HZ / 1_000_000;
    localparam int unsigned PW       = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int unsigned START_US = (SENSOR_TYPE == 1) ? 1100 : 18000;

    typedef enum logic [3:0] {
        StPwrup,
        StIdle,
        StStartLow,
        StRelease,
        StRespLow,
        StRespHigh,
        StBitLow,
        StBitHigh,
        StCheck,
        StErr,
        StGap
    } state_e;

    state_e       state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic         tick;
    logic [15:0]  tm_q, tm_d;
    logic [9:0]   us_q, us_d;
    logic [15:0]  ms_q, ms_d;
    logic         gap_clr, gap_done;
    logic [1:0]   sync_q;
    logic         data_s, data_f;
    logic         rel_hi_q, rel_hi_d;
    logic [39:0]  frame_q, frame_d;
    logic [5:0]   bits_q, bits_d;
    logic [15:0]  hum_q, hum_d, temp_q, temp_d;
    logic         valid_q, valid_d, err_q, err_d, busy_q, busy_d, drive_q, drive_d;
    logic [2:0]   err_code_q, err_code_d;
    logic [7:0]   sum;
    logic         expire, bit_val;

    // Open-drain: the only thing this block ever drives is a low level.
    assign data = drive_q ? 1'b0 : 1'bz;

    always_comb begin
        tick    = (presc_q == PW'(PRESC - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    assign data_s = sync_q[1];

`ifdef DHT_GLITCH_FILTER_EN
    logic [1:0] hist_q, hist_d;
    logic       filt_q, filt_d;
    logic       stable;

    always_comb begin
        hist_d = {hist_q[0], data_s};
        stable = (hist_q == {2{data_s}});
        data_f = stable ? data_s : filt_q;
        filt_d = data_f;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= 2'b11;
            filt_q <= 1'b1;
        end else begin
            hist_q <= hist_d;
            filt_q <= filt_d;
        end
    end
`else
    assign data_f = data_s;
`endif

    // Gap timer counts whole ms since the last transaction start (or since reset).
    always_comb begin
        us_d = us_q;
        ms_d = ms_q;
        if (gap_clr) begin
            us_d = '0;
            ms_d = '0;
        end else if (tick) begin
            if (us_q == 10'd999) begin
                us_d = '0;
                if (ms_q != 16'hFFFF) ms_d = ms_q + 16'd1;
            end else begin
                us_d = us_q + 10'd1;
            end
        end
        gap_done = (ms_q >= 16'(GAP_MS));
    end

    always_comb begin
        sum     = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
        expire  = tick && (tm_q >= 16'd99);
        bit_val = (tm_q > 16'(BIT_THRESH_US));
    end

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        err_d      = 1'b0;
        valid_d    = 1'b0;
        hum_d      = hum_q;
        temp_d     = temp_q;
        frame_d    = frame_q;
        bits_d     = bits_q;
        rel_hi_d   = rel_hi_q;
        gap_clr    = 1'b0;
        unique case (state_q)
            StPwrup: begin
                if (gap_done) state_d = StIdle;
            end
            StIdle: begin
                if (start || (auto_en && gap_done)) begin
                    state_d = StStartLow;
                    gap_clr = 1'b1;
                    frame_d = '0;
                    bits_d  = '0;
                end
            end
            StStartLow: begin
                if (tick && (tm_q >= 16'(START_US - 1))) begin
                    state_d  = StRelease;
                    rel_hi_d = 1'b0;
                end
            end
            StRelease: begin
                // Our own low lingers in the synchroniser; only a low after a seen high counts.
                if (data_f) rel_hi_d = 1'b1;
                if (rel_hi_q && !data_f) begin
                    state_d = StRespLow;
                end else if (expire) begin
                    state_d    = StErr;
                    err_d      = 1'b1;
                    err_code_d = 3'd1;
                end
            end
            StRespLow, StRespHigh: begin
                if (data_f == (state_q == StRespLow)) begin
                    state_d = (state_q == StRespLow) ? StRespHigh : StBitLow;
                end else if (expire) begin
                    state_d    = StErr;
                    err_d      = 1'b1;
                    err_code_d = 3'd2;
                end
            end
            StBitLow: begin
                if (data_f) begin
                    state_d = StBitHigh;
                end else if (expire) begin
                    state_d    = StErr;
                    err_d      = 1'b1;
                    err_code_d = 3'd3;
                end
            end
            StBitHigh: begin
                if (!data_f) begin
                    frame_d = {frame_q[38:0], bit_val};
                    bits_d  = bits_q + 6'd1;
                    state_d = (bits_q == 6'd39) ? StCheck : StBitLow;
                end else if (expire) begin
                    state_d    = StErr;
                    err_d      = 1'b1;
                    err_code_d = 3'd3;
                end
            end
            StCheck: begin
                if (sum == frame_q[7:0]) begin
                    hum_d   = frame_q[39:24];
                    temp_d  = frame_q[23:8];
                    valid_d = 1'b1;
                    state_d = StGap;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = 3'd4;
                    state_d    = StErr;
                end
            end
            StErr: begin
                state_d = StGap;
            end
            StGap: begin
                if (gap_done) state_d = StIdle;
            end
            default: begin
                state_d = StPwrup;
            end
        endcase
    end

    always_comb begin
        if (state_d != state_q) begin
            tm_d = '0;
        end else if (tick && (tm_q != 16'hFFFF)) begin
            tm_d = tm_q + 16'd1;
        end else begin
            tm_d = tm_q;
        end
        busy_d  = (state_d inside {StStartLow, StRelease, StRespLow, StRespHigh, StBitLow,
                                   StBitHigh, StCheck, StErr});
        drive_d = (state_d == StStartLow);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StPwrup;
            presc_q    <= '0;
            tm_q       <= '0;
            us_q       <= '0;
            ms_q       <= '0;
            sync_q     <= 2'b11;
            rel_hi_q   <= 1'b0;
            frame_q    <= '0;
            bits_q     <= '0;
            hum_q      <= '0;
            temp_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            drive_q    <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            tm_q       <= tm_d;
            us_q       <= us_d;
            ms_q       <= ms_d;
            sync_q     <= {sync_q[0], data};
            rel_hi_q   <= rel_hi_d;
            frame_q    <= frame_d;
            bits_q     <= bits_d;
            hum_q      <= hum_d;
            temp_q     <= temp_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            drive_q    <= drive_d;
            err_code_q <= err_code_d;
        end
    end

    assign humidity    = hum_q;
    assign temperature = temp_q;
    assign valid       = valid_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign err_code    = err_code_q;

endmodule
